// File: rtl/debug_unit_pkg.sv
// Shared command codes, status byte and FSM state type for the host debug unit.
package debug_unit_pkg;
    localparam logic [7:0] CMD_LOAD    = 8'h4C;
    localparam logic [7:0] CMD_RUN     = 8'h43;
    localparam logic [7:0] CMD_STEP    = 8'h53;
    localparam logic [7:0] CMD_RST_PC  = 8'h50;
    localparam logic [7:0] STATUS_HALT = 8'h48;

    typedef enum logic [3:0] {
        IDLE,
        LOAD_CNT,
        LOAD_BYTE,
        LOAD_WRITE,
        RST_PC,
        RUN,
        STEP,
        DUMP_ADDR,
        DUMP_CAP,
        DUMP_SEND,
        DUMP_WAIT
    } state_e;
endpackage

// File: rtl/debug_unit_if.sv
// UART byte streams plus the pipeline-side dunit bus; slave is the debug unit, master the host/CPU side.
interface debug_unit_if #(
    parameter int NB_REG  = 32,
    parameter int NB_BYTE = 8
);
    logic [NB_BYTE-1:0] i_rx_data;
    logic               i_rx_valid;
    logic [NB_BYTE-1:0] o_tx_data;
    logic               o_tx_start;
    logic               i_tx_done;
    logic               i_halt;
    logic [NB_REG-1:0]  i_dunit_reg;
    logic [NB_REG-1:0]  i_dunit_mem_data;
    logic               o_dunit_clk_en;
    logic               o_dunit_reset_pc;
    logic               o_dunit_w_mem;
    logic [NB_REG-1:0]  o_dunit_addr;
    logic [NB_REG-1:0]  o_dunit_data_if;

    modport slave (
        input  i_rx_data, i_rx_valid, i_tx_done, i_halt, i_dunit_reg, i_dunit_mem_data,
        output o_tx_data, o_tx_start, o_dunit_clk_en, o_dunit_reset_pc, o_dunit_w_mem,
               o_dunit_addr, o_dunit_data_if
    );

    modport master (
        output i_rx_data, i_rx_valid, i_tx_done, i_halt, i_dunit_reg, i_dunit_mem_data,
        input  o_tx_data, o_tx_start, o_dunit_clk_en, o_dunit_reset_pc, o_dunit_w_mem,
               o_dunit_addr, o_dunit_data_if
    );
endinterface

// File: rtl/dunit_word_shifter.sv
// Byte<->word shifter: packs rx bytes MSB first into a word, or unpacks a captured word MSB first.
module dunit_word_shifter #(
    parameter int NB_BYTE = 8,
    parameter int N_BYTES = 4,
    parameter int NB_WORD = NB_BYTE * N_BYTES,
    parameter int NB_CNT  = $clog2(N_BYTES) + 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clr_i,
    input  logic               push_i,
    input  logic [NB_BYTE-1:0] byte_i,
    input  logic               cap_i,
    input  logic [NB_WORD-1:0] word_i,
    input  logic               pop_i,
    output logic [NB_WORD-1:0] word_o,
    output logic [NB_BYTE-1:0] byte_o,
    output logic [NB_CNT-1:0]  cnt_o,
    output logic               done_o
);
    localparam logic [NB_CNT-1:0] CNT_FULL = NB_CNT'(N_BYTES);

    logic [NB_WORD-1:0] word_q;
    logic [NB_CNT-1:0]  cnt_q;

    // A push into a full word restarts the count at 1 so back-to-back load words need no clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (cap_i) begin
            word_q <= word_i;
            cnt_q  <= '0;
        end else if (push_i) begin
            word_q <= {word_q[NB_WORD-NB_BYTE-1:0], byte_i};
            cnt_q  <= (cnt_q == CNT_FULL) ? NB_CNT'(1) : cnt_q + NB_CNT'(1);
        end else if (pop_i) begin
            word_q <= {word_q[NB_WORD-NB_BYTE-1:0], {NB_BYTE{1'b0}}};
            cnt_q  <= cnt_q + NB_CNT'(1);
        end
    end

    assign word_o = word_q;
    assign byte_o = word_q[NB_WORD-1 -: NB_BYTE];
    assign cnt_o  = cnt_q;
    assign done_o = (cnt_q == CNT_FULL);
endmodule

// File: rtl/debug_unit.sv
// Host debug controller: decodes UART commands, loads imem, gates the pipeline clock and dumps state.
module debug_unit
    import debug_unit_pkg::*;
#(
    parameter int NB_REG      = 32,
    parameter int NB_BYTE     = 8,
    parameter int N_REGS      = 32,
    parameter int N_MEM_WORDS = 32,
    parameter int IMEM_WORDS  = 128
) (
    input logic          i_clk,
    input logic          i_reset,
    debug_unit_if.slave  dbg
);
    localparam int N_WB    = NB_REG / NB_BYTE;
    localparam int N_ITEMS = 1 + N_REGS + N_MEM_WORDS;
    localparam int NB_IDX  = NB_BYTE + 1;
    localparam int NB_ITEM = $clog2(N_ITEMS) + 1;
    localparam int NB_SCNT = $clog2(N_WB) + 1;

    state_e              state_q;
    logic [NB_BYTE-1:0]  nwords_q;
    logic [NB_IDX-1:0]   idx_q;
    logic [NB_ITEM-1:0]  item_q;
    logic                en_q, rst_pc_q, w_mem_q, tx_start_q;
    logic [NB_BYTE-1:0]  tx_data_q;
    logic [NB_REG-1:0]   addr_q, data_q;

    logic                sh_clr, sh_push, sh_cap, sh_pop, sh_done, last_word, item_last_byte;
    logic [NB_REG-1:0]   sh_word_in, sh_word;
    logic [NB_BYTE-1:0]  sh_byte, status;
    logic [NB_SCNT-1:0]  sh_cnt;

    // Item 0 is the status byte, then registers by index, then dmem words by byte address.
    function automatic logic [NB_REG-1:0] dump_addr(input logic [NB_ITEM-1:0] item);
        if (item == '0)
            return '0;
        else if (item <= NB_ITEM'(N_REGS))
            return NB_REG'(item - NB_ITEM'(1));
        else
            return NB_REG'(item - NB_ITEM'(N_REGS + 1)) << 2;
    endfunction

    assign status         = dbg.i_halt ? STATUS_HALT : '0;
    assign last_word      = (idx_q + NB_IDX'(1)) == NB_IDX'(nwords_q);
    assign sh_clr         = (state_q == LOAD_CNT) && dbg.i_rx_valid;
    assign sh_push        = dbg.i_rx_valid &&
                            ((state_q == LOAD_BYTE) || ((state_q == LOAD_WRITE) && !last_word));
    assign sh_cap         = (state_q == DUMP_CAP);
    assign sh_pop         = (state_q == DUMP_SEND);
    assign sh_word_in     = (item_q == '0) ? {status, {(NB_REG-NB_BYTE){1'b0}}} :
                            (item_q <= NB_ITEM'(N_REGS)) ? dbg.i_dunit_reg : dbg.i_dunit_mem_data;
    assign item_last_byte = (item_q == '0) ? (sh_cnt == NB_SCNT'(1)) : sh_done;

    dunit_word_shifter #(
        .NB_BYTE (NB_BYTE),
        .N_BYTES (N_WB)
    ) u_shifter (
        .clk_i  (i_clk),
        .rst_i  (i_reset),
        .clr_i  (sh_clr),
        .push_i (sh_push),
        .byte_i (dbg.i_rx_data),
        .cap_i  (sh_cap),
        .word_i (sh_word_in),
        .pop_i  (sh_pop),
        .word_o (sh_word),
        .byte_o (sh_byte),
        .cnt_o  (sh_cnt),
        .done_o (sh_done)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= IDLE;
            nwords_q   <= '0;
            idx_q      <= '0;
            item_q     <= '0;
            en_q       <= 1'b0;
            rst_pc_q   <= 1'b0;
            w_mem_q    <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            rst_pc_q   <= 1'b0;
            w_mem_q    <= 1'b0;
            tx_start_q <= 1'b0;
            case (state_q)
                IDLE: if (dbg.i_rx_valid) begin
                    case (dbg.i_rx_data)
                        CMD_LOAD:   state_q <= LOAD_CNT;
                        CMD_RUN:    begin en_q <= 1'b1; state_q <= RUN; end
                        CMD_STEP:   begin en_q <= 1'b1; state_q <= STEP; end
                        CMD_RST_PC: begin en_q <= 1'b1; rst_pc_q <= 1'b1; state_q <= RST_PC; end
                        default:    ;
                    endcase
                end
                LOAD_CNT: if (dbg.i_rx_valid) begin
                    nwords_q <= dbg.i_rx_data;
                    idx_q    <= '0;
                    state_q  <= (dbg.i_rx_data == '0) ? IDLE : LOAD_BYTE;
                end
                LOAD_BYTE: if (dbg.i_rx_valid && sh_cnt == NB_SCNT'(N_WB - 1)) state_q <= LOAD_WRITE;
                LOAD_WRITE: begin
                    w_mem_q <= 1'b1;
                    data_q  <= sh_word;
                    addr_q  <= (NB_REG'(idx_q) % NB_REG'(IMEM_WORDS)) << 2;
                    idx_q   <= idx_q + NB_IDX'(1);
                    state_q <= last_word ? IDLE : LOAD_BYTE;
                end
                RST_PC: begin
                    en_q    <= 1'b0;
                    state_q <= IDLE;
                end
                RUN: if (dbg.i_halt) begin
                    en_q    <= 1'b0;
                    item_q  <= '0;
                    addr_q  <= dump_addr('0);
                    state_q <= DUMP_ADDR;
                end
                STEP: begin
                    en_q    <= 1'b0;
                    item_q  <= '0;
                    addr_q  <= dump_addr('0);
                    state_q <= DUMP_ADDR;
                end
                DUMP_ADDR: state_q <= DUMP_CAP;
                DUMP_CAP:  state_q <= DUMP_SEND;
                DUMP_SEND: begin
                    tx_data_q  <= sh_byte;
                    tx_start_q <= 1'b1;
                    state_q    <= DUMP_WAIT;
                end
                DUMP_WAIT: if (dbg.i_tx_done) begin
                    if (!item_last_byte) begin
                        state_q <= DUMP_SEND;
                    end else if (item_q == NB_ITEM'(N_ITEMS - 1)) begin
                        state_q <= IDLE;
                    end else begin
                        item_q  <= item_q + NB_ITEM'(1);
                        addr_q  <= dump_addr(item_q + NB_ITEM'(1));
                        state_q <= DUMP_ADDR;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Halt gates the enable in the same cycle it is seen so the pipeline never advances past it.
    assign dbg.o_dunit_clk_en   = en_q & ~(((state_q == RUN) || (state_q == STEP)) & dbg.i_halt);
    assign dbg.o_dunit_reset_pc = rst_pc_q;
    assign dbg.o_dunit_w_mem    = w_mem_q;
    assign dbg.o_dunit_addr     = addr_q;
    assign dbg.o_dunit_data_if  = data_q;
    assign dbg.o_tx_data        = tx_data_q;
    assign dbg.o_tx_start       = tx_start_q;
endmodule

// File: tb/tb_debug_unit.sv
// Scoreboard bench for debug_unit: expected imem writes and tx bytes are queued at stimulus time.
module tb_debug_unit;
    import debug_unit_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    debug_unit_if #(.NB_REG(32), .NB_BYTE(8)) dif ();

    debug_unit #(
        .NB_REG      (32),
        .NB_BYTE     (8),
        .N_REGS      (32),
        .N_MEM_WORDS (32),
        .IMEM_WORDS  (128)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .dbg     (dif)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int en_cnt = 0, rpc_cnt = 0, both_cnt = 0, tx_starts = 0;
    int tx_early = 0, tx_unstable = 0;
    int tx_delay = 2;
    logic [7:0]  txq[$];
    logic [63:0] wq[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] reg_val(input logic [31:0] a);
        return {8'hA0 ^ a[7:0], a[7:0] + 8'h11, 8'h5A, ~a[7:0]};
    endfunction

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        logic [7:0] k;
        k = a[9:2];
        return {8'h3C, k, 8'hF0 ^ k, k + 8'h77};
    endfunction

    assign dif.i_dunit_reg      = reg_val(dif.o_dunit_addr);
    assign dif.i_dunit_mem_data = mem_val(dif.o_dunit_addr);

    always @(negedge clk) begin
        if (!rst) begin
            en_cnt   += int'(dif.o_dunit_clk_en);
            rpc_cnt  += int'(dif.o_dunit_reset_pc);
            both_cnt += int'(dif.o_dunit_clk_en & dif.o_dunit_reset_pc);
            if (dif.o_dunit_w_mem) begin
                if (wq.size() == 0) begin
                    chk("wmem_unexpected", 32'd1, 32'd0);
                end else begin
                    logic [63:0] e;
                    e = wq.pop_front();
                    chk("wmem_addr", dif.o_dunit_addr, e[63:32]);
                    chk("wmem_data", dif.o_dunit_data_if, e[31:0]);
                end
            end
        end
    end

    // Transmitter model: done after tx_delay cycles; flags early starts or data moving while busy.
    initial begin
        dif.i_tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && dif.o_tx_start) begin
                logic [7:0] b;
                b = dif.o_tx_data;
                tx_starts++;
                if (txq.size() == 0) chk("tx_unexpected", 32'd1, 32'd0);
                else chk("tx_byte", {24'h0, b}, {24'h0, txq.pop_front()});
                repeat (tx_delay) begin
                    @(negedge clk);
                    if (!rst && dif.o_tx_start) tx_early++;
                    if (!rst && dif.o_tx_data !== b) tx_unstable++;
                end
                dif.i_tx_done = 1'b1;
                @(negedge clk);
                dif.i_tx_done = 1'b0;
            end
        end
    end

    task automatic send_raw(input logic [7:0] b);
        @(negedge clk);
        dif.i_rx_data  = b;
        dif.i_rx_valid = 1'b1;
        @(negedge clk);
        dif.i_rx_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_raw(b);
        repeat (3) @(negedge clk);
    endtask

    task automatic push_dump(input logic [7:0] st);
        logic [31:0] w;
        txq.push_back(st);
        for (int k = 0; k < 32; k++) begin
            w = reg_val(32'(k));
            for (int b = 3; b >= 0; b--) txq.push_back(w[8*b +: 8]);
        end
        for (int k = 0; k < 32; k++) begin
            w = mem_val(32'(4 * k));
            for (int b = 3; b >= 0; b--) txq.push_back(w[8*b +: 8]);
        end
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int i;
        i = 0;
        while (txq.size() != 0 && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk(tag, txq.size(), 0);
        repeat (tx_delay + 8) @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_tx_data"},  {24'h0, dif.o_tx_data}, 32'h0);
        chk({tag, "_tx_start"}, {31'h0, dif.o_tx_start}, 32'h0);
        chk({tag, "_clk_en"},   {31'h0, dif.o_dunit_clk_en}, 32'h0);
        chk({tag, "_reset_pc"}, {31'h0, dif.o_dunit_reset_pc}, 32'h0);
        chk({tag, "_w_mem"},    {31'h0, dif.o_dunit_w_mem}, 32'h0);
        chk({tag, "_addr"},     dif.o_dunit_addr, 32'h0);
        chk({tag, "_data_if"},  dif.o_dunit_data_if, 32'h0);
    endtask

    task automatic pulse_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_outputs_zero(tag);
        txq.delete();
        wq.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int en0, rpc0, both0, tx0;
        logic [31:0] w;
        rst = 1'b1;
        dif.i_rx_data  = '0;
        dif.i_rx_valid = 1'b0;
        dif.i_halt     = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Two-word load from the reference program
        en0 = en_cnt;
        wq.push_back({32'h0, 32'h20080005});
        wq.push_back({32'h4, 32'hFC000000});
        send_byte(CMD_LOAD); send_byte(8'h02);
        send_byte(8'h20); send_byte(8'h08); send_byte(8'h00); send_byte(8'h05);
        send_byte(8'hFC); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        repeat (4) @(negedge clk);
        chk("load_writes_left", wq.size(), 0);
        chk("load_clk_en", en_cnt - en0, 0);

        // Zero-word load writes nothing and returns to command decode
        send_byte(CMD_LOAD); send_byte(8'h00);

        // Reset PC
        en0 = en_cnt; rpc0 = rpc_cnt; both0 = both_cnt; tx0 = tx_starts;
        send_byte(CMD_RST_PC);
        repeat (5) @(negedge clk);
        chk("rpc_pulses", rpc_cnt - rpc0, 1);
        chk("rpc_clk_en", en_cnt - en0, 1);
        chk("rpc_overlap", both_cnt - both0, 1);
        chk("rpc_no_tx", tx_starts - tx0, 0);

        // Step, slow transmitter, stray rx bytes during the dump
        tx_delay = 50;
        dif.i_halt = 1'b0;
        push_dump(8'h00);
        en0 = en_cnt; tx0 = tx_starts; tx_early = 0; tx_unstable = 0;
        send_raw(CMD_STEP);
        repeat (20) @(negedge clk);
        send_byte(CMD_RUN); send_byte(CMD_LOAD); send_byte(CMD_STEP); send_byte(CMD_RST_PC);
        wait_drain("step_drain", 257 * 60);
        chk("step_clk_en", en_cnt - en0, 1);
        chk("step_bytes", tx_starts - tx0, 257);
        chk("step_early_start", tx_early, 0);
        chk("step_tx_unstable", tx_unstable, 0);

        // Run with halt raised after 10 enabled cycles
        tx_delay = 5;
        push_dump(STATUS_HALT);
        en0 = en_cnt; tx0 = tx_starts; tx_early = 0;
        send_raw(CMD_RUN);
        for (int i = 0; i < 200 && (en_cnt - en0) < 10; i++) begin
            @(posedge clk);
            #1;
        end
        dif.i_halt = 1'b1;
        wait_drain("run_drain", 257 * 15);
        chk("run_clk_en", en_cnt - en0, 10);
        chk("run_bytes", tx_starts - tx0, 257);
        chk("run_early_start", tx_early, 0);

        // Run with halt already set
        en0 = en_cnt;
        push_dump(STATUS_HALT);
        send_byte(CMD_RUN);
        wait_drain("run_halted_drain", 257 * 15);
        chk("run_halted_clk_en", en_cnt - en0, 0);
        dif.i_halt = 1'b0;

        // 130-word load wraps the imem address after 128 words
        for (int i = 0; i < 130; i++) wq.push_back({32'(4 * (i % 128)), 32'h1000_0000 + 32'(i * 3)});
        send_byte(CMD_LOAD); send_byte(8'd130);
        for (int i = 0; i < 130; i++) begin
            w = 32'h1000_0000 + 32'(i * 3);
            for (int b = 3; b >= 0; b--) send_byte(w[8*b +: 8]);
        end
        repeat (4) @(negedge clk);
        chk("wrap_writes_left", wq.size(), 0);

        // Reset in the middle of a load, then a clean one-word load
        send_byte(CMD_LOAD); send_byte(8'h02); send_byte(8'h11); send_byte(8'h22);
        pulse_reset("rst_load");
        wq.push_back({32'h0, 32'hDEADBEEF});
        send_byte(CMD_LOAD); send_byte(8'h01);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        repeat (4) @(negedge clk);
        chk("rst_load_writes_left", wq.size(), 0);

        // Reset in the middle of a dump, then a clean one-word load
        push_dump(8'h00);
        send_raw(CMD_STEP);
        repeat (150) @(negedge clk);
        pulse_reset("rst_dump");
        repeat (20) @(negedge clk);
        wq.push_back({32'h0, 32'h0BAD_F00D});
        send_byte(CMD_LOAD); send_byte(8'h01);
        send_byte(8'h0B); send_byte(8'hAD); send_byte(8'hF0); send_byte(8'h0D);
        repeat (4) @(negedge clk);
        chk("rst_dump_writes_left", wq.size(), 0);
        chk("final_tx_left", txq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
